// File: rtl/top_stm_game.sv
// Game sequencer: steps the display, edit and check engines through each move,
// rotating players, counting moves, detecting win/draw and guarding engines with a watchdog.
module top_stm_game #(
  parameter int NUM_PLAYERS = 2,
  parameter int BOARD_CELLS = 42,
  parameter int TIMEOUT_CYC = 1024,
  localparam int PW = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int MW = $clog2(BOARD_CELLS + 1),
  localparam int TW = ($clog2(TIMEOUT_CYC + 1) > 1) ? $clog2(TIMEOUT_CYC + 1) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          usr_en,
  input  logic          new_game,
  input  logic          display_finish,
  input  logic          edit_finish,
  input  logic          edit_invalid,
  input  logic          check_finish,
  input  logic          check_4,
  output logic          edit_en,
  output logic          display_en,
  output logic          check_en,
  output logic [2:0]    row_addr_sel,
  output logic [PW-1:0] cur_player,
  output logic [PW-1:0] winner,
  output logic          game_over,
  output logic          is_draw,
  output logic          timeout_err,
  output logic [MW-1:0] move_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_EDIT, S_CHECK, S_RELEASE, S_REJECT, S_WIN, S_DRAW, S_FAULT
  } state_t;

  // Expiry is flagged on the TIMEOUT_CYC-th cycle spent in a guarded state.
  localparam int WD_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  state_t        state, state_nxt;
  logic [TW-1:0] wd;
  logic          wd_exp;
  logic          board_full;

  assign wd_exp     = (TIMEOUT_CYC != 0) && (wd == TW'(WD_LAST));
  assign board_full = (move_count == MW'(BOARD_CELLS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cur_player  <= '0;
      winner      <= '0;
      move_count  <= '0;
      wd          <= '0;
      game_over   <= 1'b0;
      is_draw     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      game_over   <= (state_nxt == S_WIN) || (state_nxt == S_DRAW);
      is_draw     <= (state_nxt == S_DRAW);
      timeout_err <= (state_nxt == S_FAULT);
      if (new_game) begin
        cur_player <= '0;
        winner     <= '0;
        move_count <= '0;
        wd         <= '0;
      end else begin
        if (state != state_nxt)
          wd <= '0;
        else if ((state == S_EDIT || state == S_CHECK) && wd != {TW{1'b1}})
          wd <= wd + TW'(1);
        if (state == S_EDIT && state_nxt == S_CHECK && !board_full)
          move_count <= move_count + MW'(1);
        if (state == S_CHECK && state_nxt == S_WIN)
          winner <= cur_player;
        if (state == S_CHECK && state_nxt == S_RELEASE)
          cur_player <= (cur_player == PW'(NUM_PLAYERS - 1)) ? '0 : cur_player + PW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (usr_en && display_finish) state_nxt = S_EDIT;
      S_EDIT: begin
        if (edit_finish)       state_nxt = S_CHECK;
        else if (edit_invalid) state_nxt = S_REJECT;
        else if (wd_exp)       state_nxt = S_FAULT;
      end
      S_CHECK: begin
        if (check_4)           state_nxt = S_WIN;
        else if (check_finish) state_nxt = board_full ? S_DRAW : S_RELEASE;
        else if (wd_exp)       state_nxt = S_FAULT;
      end
      S_RELEASE, S_REJECT: if (!usr_en) state_nxt = S_IDLE;
      S_WIN, S_DRAW, S_FAULT: state_nxt = state;
      default:   state_nxt = S_IDLE;
    endcase
    if (new_game) state_nxt = S_IDLE;
  end

  always_comb begin
    edit_en      = 1'b0;
    display_en   = 1'b0;
    check_en     = 1'b0;
    row_addr_sel = 3'b001;
    case (state)
      S_EDIT: begin
        edit_en      = ~(edit_finish | edit_invalid);
        row_addr_sel = 3'b010;
      end
      S_CHECK: begin
        check_en     = ~(check_4 | check_finish);
        row_addr_sel = 3'b100;
      end
      S_RELEASE, S_REJECT, S_WIN, S_DRAW, S_FAULT: display_en = 1'b1;
      default: display_en = ~(usr_en & display_finish);
    endcase
  end

endmodule

// File: tb/tb_top_stm_game.sv
// Scoreboard bench for top_stm_game: driver queues hand-computed expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_top_stm_game;
  logic clk = 1'b0, rst = 1'b1;
  logic usr_en = 0, new_game = 0, display_finish = 0, edit_finish = 0, edit_invalid = 0;
  logic check_finish = 0, check_4 = 0;
  logic edit_en, display_en, check_en, game_over, is_draw, timeout_err;
  logic [2:0] row_addr_sel, move_count;
  logic [1:0] cur_player, winner;

  top_stm_game #(.NUM_PLAYERS(3), .BOARD_CELLS(4), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .usr_en(usr_en), .new_game(new_game),
    .display_finish(display_finish), .edit_finish(edit_finish), .edit_invalid(edit_invalid),
    .check_finish(check_finish), .check_4(check_4), .edit_en(edit_en), .display_en(display_en),
    .check_en(check_en), .row_addr_sel(row_addr_sel), .cur_player(cur_player), .winner(winner),
    .game_over(game_over), .is_draw(is_draw), .timeout_err(timeout_err), .move_count(move_count)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] U = 7'b1000000, DF = 7'b0100000, EF = 7'b0010000, EI = 7'b0001000;
  localparam logic [6:0] CF = 7'b0000100, C4 = 7'b0000010, NG = 7'b0000001, NONE = 7'b0;

  logic [15:0] exp_q[$];
  string       name_q[$];
  int checks = 0, fails = 0;

  wire [15:0] act = {edit_en, display_en, check_en, row_addr_sel, cur_player, winner,
                     game_over, is_draw, timeout_err, move_count};

  function automatic logic [15:0] ob(input logic ee, de, ce, input logic [2:0] sel,
                                     input logic [1:0] cp, wn, input logic go, dr, to,
                                     input logic [2:0] mc);
    return {ee, de, ce, sel, cp, wn, go, dr, to, mc};
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [15:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (act !== e) begin
        fails++;
        $display("FAIL %s: got ee/de/ce/sel/cp/wn/go/dr/to/mc=%b want %b", nm, act, e);
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic [6:0] iv, input logic [15:0] e);
    @(posedge clk);
    #1;
    rst = r;
    {usr_en, display_finish, edit_finish, edit_invalid, check_finish, check_4, new_game} = iv;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic full_move(input logic [1:0] cpb, cpa, input logic [2:0] mcb);
    step("mv_idle",    0, U | DF, ob(0, 0, 0, 3'b001, cpb, 0, 0, 0, 0, mcb));
    step("mv_edit",    0, U | EF, ob(0, 0, 0, 3'b010, cpb, 0, 0, 0, 0, mcb));
    step("mv_check",   0, U | CF, ob(0, 0, 0, 3'b100, cpb, 0, 0, 0, 0, mcb + 3'd1));
    step("mv_release", 0, NONE,   ob(0, 1, 0, 3'b001, cpa, 0, 0, 0, 0, mcb + 3'd1));
  endtask

  initial begin
    // reset and first move, player 0
    step("reset",        1, NONE,   ob(0, 1, 0, 3'b001, 0, 0, 0, 0, 0, 0));
    step("idle_go",      0, U | DF, ob(0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0));
    step("edit_wait",    0, U,      ob(1, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0));
    step("edit_done",    0, U | EF, ob(0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0));
    step("check_wait",   0, U,      ob(0, 0, 1, 3'b100, 0, 0, 0, 0, 0, 1));
    step("check_done",   0, U | CF, ob(0, 0, 0, 3'b100, 0, 0, 0, 0, 0, 1));
    step("release_hold", 0, U,      ob(0, 1, 0, 3'b001, 1, 0, 0, 0, 0, 1));
    step("release_go",   0, NONE,   ob(0, 1, 0, 3'b001, 1, 0, 0, 0, 0, 1));
    step("idle_back",    0, NONE,   ob(0, 1, 0, 3'b001, 1, 0, 0, 0, 0, 1));
    // rotation 1 -> 2 -> 0 with three players
    full_move(2'd1, 2'd2, 3'd1);
    full_move(2'd2, 2'd0, 3'd2);
    // rejected move, then simultaneous finish+invalid filling the board -> draw
    step("rej_idle",     0, U | DF,      ob(0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 3));
    step("rej_invalid",  0, U | EI,      ob(0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 3));
    step("reject_hold",  0, U,           ob(0, 1, 0, 3'b001, 0, 0, 0, 0, 0, 3));
    step("reject_go",    0, NONE,        ob(0, 1, 0, 3'b001, 0, 0, 0, 0, 0, 3));
    step("retry_idle",   0, U | DF,      ob(0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 3));
    step("both_finish",  0, U | EF | EI, ob(0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 3));
    step("last_check",   0, U | CF,      ob(0, 0, 0, 3'b100, 0, 0, 0, 0, 0, 4));
    step("draw",         0, U,           ob(0, 1, 0, 3'b001, 0, 0, 1, 1, 0, 4));
    step("draw_held",    0, U | DF,      ob(0, 1, 0, 3'b001, 0, 0, 1, 1, 0, 4));
    step("draw_newgame", 0, NG,          ob(0, 1, 0, 3'b001, 0, 0, 1, 1, 0, 4));
    step("ng_cleared",   0, NONE,        ob(0, 1, 0, 3'b001, 0, 0, 0, 0, 0, 0));
    // player 1 wins with check_4 and check_finish together
    full_move(2'd0, 2'd1, 3'd0);
    step("win_idle",     0, U | DF,      ob(0, 0, 0, 3'b001, 1, 0, 0, 0, 0, 1));
    step("win_edit",     0, U | EF,      ob(0, 0, 0, 3'b010, 1, 0, 0, 0, 0, 1));
    step("win_check",    0, U | CF | C4, ob(0, 0, 0, 3'b100, 1, 0, 0, 0, 0, 2));
    step("win",          0, NONE,        ob(0, 1, 0, 3'b001, 1, 1, 1, 0, 0, 2));
    step("win_newgame",  0, NG,          ob(0, 1, 0, 3'b001, 1, 1, 1, 0, 0, 2));
    step("win_cleared",  0, NONE,        ob(0, 1, 0, 3'b001, 0, 0, 0, 0, 0, 0));
    // watchdog expiry in EDIT
    step("wd_idle",      0, U | DF,      ob(0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      step("wd_edit",    0, U,           ob(1, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0));
    step("fault",        0, U,           ob(0, 1, 0, 3'b001, 0, 0, 0, 0, 1, 0));
    step("fault_ng",     0, U | NG,      ob(0, 1, 0, 3'b001, 0, 0, 0, 0, 1, 0));
    // finish on the expiry cycle wins over the timeout
    step("wd2_idle",     0, U | DF,      ob(0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 7; i++)
      step("wd2_edit",   0, U,           ob(1, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0));
    step("finish_on_expiry", 0, U | EF,  ob(0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0));
    step("check_no_fault",   0, U,       ob(0, 0, 1, 3'b100, 0, 0, 0, 0, 0, 1));
    // async reset mid-move, sampled before any clock edge
    step("async_rst",    1, U,           ob(0, 1, 0, 3'b001, 0, 0, 0, 0, 0, 0));
    step("post_rst",     0, NONE,        ob(0, 1, 0, 3'b001, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/top_stm_game.md
Name: top_stm_game

Overview:
- Parametrised successor of the Connect4 top-level sequencer.
- Sequences the display, edit and check engines through a move.
- Adds the following beyond a single-move sequencer:
  - N-player turn rotation
  - move counting with draw detection
  - rejected-move recovery
  - per-engine watchdog timeout
  - synchronous new-game restart
- Sits between the user-input debouncer and the display/edit/check engines. Drives their enables and the row-address mux select.

Parameters:
- NUM_PLAYERS, 2, number of players; legal range 2..8.
- BOARD_CELLS, 42, moves that fill the board; reaching this count with no win is a draw.
- TIMEOUT_CYC, 1024, max cycles in EDIT or CHECK before fault; 0 disables the watchdog.
- Derived (localparam): PW = max(1, clog2(NUM_PLAYERS)).
- Derived (localparam): MW = clog2(BOARD_CELLS+1).
- Derived (localparam): TW = max(1, clog2(TIMEOUT_CYC+1)).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- usr_en  in  1  level: user requests/holds a move.
- new_game  in  1  single-cycle pulse: abandon current game, restart.
- display_finish  in  1  display engine idle/refresh done.
- edit_finish  in  1  edit engine placed the piece.
- edit_invalid  in  1  edit engine rejected the move (column full).
- check_finish  in  1  check engine done, no four-in-a-row.
- check_4  in  1  check engine found four-in-a-row.
- edit_en  out  1  edit engine enable.
- display_en  out  1  display engine enable.
- check_en  out  1  check engine enable.
- row_addr_sel  out  3  one-hot row-address mux select: 001 display, 010 edit, 100 check.
- cur_player  out  PW  player whose move is in progress.
- winner  out  PW  winning player; valid when game_over & !is_draw.
- game_over  out  1  high in WIN or DRAW.
- is_draw  out  1  high in DRAW.
- timeout_err  out  1  high in FAULT.
- move_count  out  MW  accepted moves this game.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; cur_player=0, winner=0, move_count=0, watchdog=0.
  - game_over=0, is_draw=0, timeout_err=0.
  - Outputs follow IDLE decode immediately.
- State register:
  - 3-bit, registered on posedge clk.
  - Enables and row_addr_sel are combinational decodes of state plus the current-cycle inputs shown below.
  - Status outputs are registered.
- IDLE:
  - display_en=~(usr_en&display_finish); row_addr_sel=001.
  - usr_en&display_finish -> EDIT.
- EDIT:
  - edit_en=~(edit_finish|edit_invalid); row_addr_sel=010.
  - edit_finish -> CHECK, move_count+1. edit_finish wins if both it and edit_invalid are high.
  - edit_invalid only -> REJECT; move_count and cur_player unchanged.
- CHECK:
  - check_en=~(check_4|check_finish); row_addr_sel=100.
  - check_4 -> WIN; winner<=cur_player. check_4 has priority over check_finish.
  - Else check_finish and move_count==BOARD_CELLS -> DRAW.
  - Else check_finish -> RELEASE; cur_player<=(cur_player==NUM_PLAYERS-1)?0:cur_player+1.
- RELEASE and REJECT:
  - display_en=1; row_addr_sel=001.
  - !usr_en -> IDLE.
- WIN and DRAW:
  - display_en=1; row_addr_sel=001; state held until new_game.
- FAULT:
  - all enables 0 except display_en=1; row_addr_sel=001; held until new_game.
- Watchdog:
  - Cleared on every state change; counts each cycle in EDIT/CHECK.
  - If it reaches TIMEOUT_CYC and the state's finish inputs are all low that cycle -> FAULT next edge.
  - A finish arriving on the expiry cycle wins over the timeout.
  - TIMEOUT_CYC=0: never faults.
- new_game:
  - Active in any state; highest priority after rst.
  - Next state IDLE; cur_player, winner, move_count, watchdog cleared.
  - Enables that cycle still follow the current state decode.
- Status flags:
  - game_over=1 iff state∈{WIN,DRAW}; is_draw=1 iff DRAW; timeout_err=1 iff FAULT.
  - Updated the same edge the state changes.
- Unused state encodings: decode as IDLE outputs, next state IDLE.
- move_count saturates at BOARD_CELLS; no wrap.

Test Plan:
1. Reset, usr_en=1, display_finish=1 -> EDIT next cycle. edit_finish one cycle -> CHECK, move_count=1. check_finish -> RELEASE, cur_player=1. usr_en=0 -> IDLE; row_addr_sel sequence 001,010,100,001.
2. NUM_PLAYERS=3: three full moves -> cur_player sequence 0,1,2,0.
3. In EDIT, edit_invalid=1 -> REJECT, edit_en=0, move_count and cur_player unchanged. Release usr_en -> IDLE. A simultaneous edit_finish&edit_invalid -> CHECK.
4. Player 1 in CHECK with check_4=1 and check_finish=1 -> WIN, winner=1, game_over=1, is_draw=0. new_game pulse -> IDLE, all counters 0.
5. BOARD_CELLS=4: four moves, no check_4 -> after 4th check_finish state DRAW, is_draw=1, game_over=1, move_count=4.
6. TIMEOUT_CYC=8: hold in EDIT with no finish -> FAULT after 8 cycles, timeout_err=1, edit_en=0. Finish on the 8th cycle -> CHECK, no fault. Assert rst mid-EDIT -> outputs at reset values without a clock edge.
